lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Multi-cycle load/store sequencer between the single-cycle core and a handshaked data-memory bus.
- Consumes the control unit's Load/Store/mem_en strobes, fun3 and the ALU-computed address.
- Drives a req/ack bus with byte strobes, stalls the core until the access completes, and returns sign/zero-extended load data.
- Flags misaligned accesses, illegal fun3 and bus timeouts.

Parameters:
- TIMEOUT_CYC, 256: max cycles in REQ without bus_ack before an access fault; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- load  input  1  Load strobe from control unit
- store  input  1  Store strobe from control unit
- mem_en  input  1  memory-enable from control unit; access considered only when high
- fun3  input  3  instruction fun3 (width/sign select)
- addr  input  32  byte address from ALU
- wdata  input  32  store data (rs2)
- stall  output  1  holds PC/register write while high
- rdata  output  32  formatted load data, valid in DONE
- misalign  output  1  one-cycle pulse: misaligned access rejected
- fault  output  1  one-cycle pulse: illegal fun3, load&store both high, or bus timeout
- bus_req  output  1  bus request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address (addr[1:0] forced 0)
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte write strobes (0 for reads)
- bus_ack  input  1  bus completion, one-cycle pulse
- bus_rdata  input  32  read word, valid with bus_ack

Behaviour:
- Reset: state IDLE; stall, bus_req, bus_we, misalign and fault are 0; bus_addr, bus_wdata, bus_wstrb, rdata and timeout counter are 0. Reset asserted mid-access drops bus_req immediately and abandons the access.
- Start condition: mem_en & (load | store).
- Legal fun3:
  - load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - store: 000 SB, 001 SH, 010 SW
- IDLE, start, legal, aligned:
  - latch addr, fun3, we, wdata and strobes
  - stall=1 combinationally in the same cycle
  - next state REQ
- IDLE, start, misaligned (half: addr[0]=1; word: addr[1:0]≠0): no bus access; misalign=1 for one cycle; stall=0; stay IDLE.
- IDLE, start with illegal fun3 or load&store both high: no bus access; fault=1 for one cycle; stall=0; stay IDLE.
- REQ:
  - bus_req=1 and stall=1; all bus_* held stable until bus_ack
  - counter increments each cycle
  - bus_ack: capture formatted bus_rdata into rdata (reads only); bus_req=0 next cycle; go DONE
  - counter reaches TIMEOUT_CYC-1 with no ack: fault=1 one cycle; rdata=0; go DONE
- DONE: stall=0 for exactly one cycle, so the core retires the instruction and writes rdata; unconditional return to IDLE. Start inputs are ignored in DONE. Latency for a zero-wait bus (ack in first REQ cycle) is 2 stall cycles.
- Store lanes:
  - SB: wstrb=1<<addr[1:0], wdata[7:0] replicated ×4
  - SH: wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata[15:0] replicated ×2
  - SW: wstrb=1111
- Load format:
  - byte lane selected by addr[1:0]; half lane selected by addr[1]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through
- rdata holds its value until the next captured load or timeout.
- bus_ack outside REQ is ignored.

Decomposition:
- Shared package lsu_pkg:
  - state enum (IDLE, REQ, DONE)
  - fun3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101)
  - strobe constants
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension (inputs: word, addr[1:0], fun3; output: 32-bit value).
- FSM, timeout counter and store-lane logic stay in lsu_controller.

Test Plan:
- LB, addr=0x1003, bus_rdata=0x80FF_1234, ack after 3 REQ cycles → bus_addr=0x1000, wstrb=0, stall high 4 cycles, DONE rdata=0xFFFF_FF80.
- SH, addr=0x2002, wdata=0x0000_ABCD, ack immediate → bus_we=1, wstrb=1100, bus_wdata=0xABCD_ABCD, stall high 2 cycles.
- LW, addr=0x3001 → no bus_req, misalign pulse 1 cycle, stall=0; then LHU, addr=0x3002, rdata=0x5A5A_F00D → rdata=0x0000_5A5A.
- TIMEOUT_CYC=4, SW with no ack → bus_req high 4 cycles, fault pulse, rdata=0, DONE then IDLE; a late ack is ignored.
- rst asserted during REQ → bus_req and stall drop without a clock edge; after release a new LBU at 0x0 with rdata 0x0000_00F0 → rdata=0x0000_00F0.
- fun3=011 load, then load&store both high → fault pulse each time, no bus activity.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   state_t      : sequencer states
//   F3_*         : fun3 encodings for access width/sign
//   STRB_*       : byte-strobe constants
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STRBW = XLEN / 8;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [STRBW-1:0] STRB_NONE = 4'b0000;
  localparam logic [STRBW-1:0] STRB_BYTE = 4'b0001;
  localparam logic [STRBW-1:0] STRB_LO   = 4'b0011;
  localparam logic [STRBW-1:0] STRB_HI   = 4'b1100;
  localparam logic [STRBW-1:0] STRB_ALL  = 4'b1111;

endpackage

// File: rtl/lsu_bus_if.sv
// Request/acknowledge data-memory bus.
//   req/we/addr/wdata/wstrb : driven by the LSU (master)
//   ack/rdata               : driven by memory (slave); rdata valid with ack
interface lsu_bus_if;
  import lsu_pkg::*;

  logic             req;
  logic             we;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic [STRBW-1:0] wstrb;
  logic             ack;
  logic [XLEN-1:0]  rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Load formatting: selects the byte/half lane from a bus word and
// sign- or zero-extends it according to fun3.
//   word    : raw 32-bit bus word
//   addr_lo : byte offset addr[1:0]
//   fun3    : access width/sign
//   value   : formatted 32-bit load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      fun3,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  always_comb begin
    shifted = word >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? word[31:16] : word[15:0];
    case (fun3)
      F3_B:    value = {{24{byte_v[7]}}, byte_v};
      F3_H:    value = {{16{half_v[15]}}, half_v};
      F3_BU:   value = {24'd0, byte_v};
      F3_HU:   value = {16'd0, half_v};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer between the core and the memory bus.
//   clk, rst            : clock, async active-high reset
//   load/store/mem_en   : control-unit strobes; start = mem_en & (load|store)
//   fun3, addr, wdata   : access width/sign, byte address, store data
//   stall               : holds the core while an access is in flight
//   rdata               : formatted load data, valid in DONE, held afterwards
//   misalign, fault     : one-cycle pulses for rejected/failed accesses
//   bus                 : master side of the req/ack memory bus
// misalign/fault are registered: a rejection in IDLE pulses on the following
// cycle; a timeout pulses in the DONE cycle.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            store,
  input  logic            mem_en,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            fault,
  lsu_bus_if.master       bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q, we_q;
  logic [XLEN-1:0]  addr_q, wdata_q;
  logic [STRBW-1:0] wstrb_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;

  logic             start, f3_legal, misaligned;
  logic             accept, mis_d, fault_d, capture, timeout, stall_c;
  logic [STRBW-1:0] lane_strb;
  logic [XLEN-1:0]  lane_wdata;
  logic [XLEN-1:0]  load_val;

  assign start = mem_en & (load | store);

  // Width/sign legality; unsigned variants exist only for loads.
  always_comb begin
    f3_legal = 1'b0;
    case (fun3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = load;
      default:          f3_legal = 1'b0;
    endcase
  end

  // Natural-alignment check.
  always_comb begin
    misaligned = 1'b0;
    case (fun3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = |addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  // Store lane placement: data replicated so any lane carries the value.
  always_comb begin
    lane_strb  = STRB_ALL;
    lane_wdata = wdata;
    case (fun3)
      F3_B: begin
        lane_strb  = STRB_BYTE << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        lane_strb  = addr[1] ? STRB_HI : STRB_LO;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        lane_strb  = STRB_ALL;
        lane_wdata = wdata;
      end
    endcase
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!f3_legal || (load && store)) begin
            fault_d = 1'b1;
          end else if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            accept  = 1'b1;
            stall_c = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (bus.ack) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates stall directly so it drops without waiting for a clock edge.
  assign stall = stall_c & ~rst;

  lsu_load_align u_load_align (
    .word    (bus.rdata),
    .addr_lo (lo_q),
    .fun3    (f3_q),
    .value   (load_val)
  );

  // State register and latched access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      f3_q     <= '0;
      lo_q     <= '0;
      rdata    <= '0;
      misalign <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= (state_d == ST_REQ);
      misalign <= mis_d;
      fault    <= fault_d;
      if (accept) begin
        we_q    <= store;
        addr_q  <= {addr[XLEN-1:2], 2'b00};
        wdata_q <= lane_wdata;
        wstrb_q <= store ? lane_strb : STRB_NONE;
        f3_q    <= fun3;
        lo_q    <= addr[1:0];
        cnt_q   <= '0;
      end else if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture && !we_q) rdata <= load_val;
      if (timeout)          rdata <= '0;
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: a vector table of complete accesses
// plus hand-written reset, timeout and late-ack sequences.
module tb_lsu_controller;

  logic        clk;
  logic        rst;
  logic        load, store, mem_en;
  logic [2:0]  fun3;
  logic [31:0] addr, wdata;
  logic        stall, misalign, fault;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  lsu_bus_if bus ();

  lsu_controller #(.TIMEOUT_CYC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .store    (store),
    .mem_en   (mem_en),
    .fun3     (fun3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .misalign (misalign),
    .fault    (fault),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, en;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd_in;
    int          ack_at;      // REQ cycle index that receives ack; 99 = never
    int          e_stall, e_reqs, e_mis, e_fault;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ld, st, en, input logic [2:0] f3,
                              input logic [31:0] a, wd, rd_in, input int ack_at,
                              input int e_stall, e_reqs, e_mis, e_fault,
                              input logic e_we, input logic [31:0] e_addr, e_wdata,
                              input logic [3:0] e_wstrb, input logic [31:0] e_rdata);
    vec_t v;
    v.ld = ld; v.st = st; v.en = en; v.f3 = f3; v.a = a; v.wd = wd; v.rd_in = rd_in;
    v.ack_at = ack_at; v.e_stall = e_stall; v.e_reqs = e_reqs; v.e_mis = e_mis;
    v.e_fault = e_fault; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wstrb = e_wstrb; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one access from the IDLE cycle and watches it for a fixed window.
  task automatic run_vec(input string tag, input vec_t v);
    int stall_cnt, req_cnt, mis_cnt, fault_cnt;
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0; fault_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      load   = (c == 0) ? v.ld : 1'b0;
      store  = (c == 0) ? v.st : 1'b0;
      mem_en = (c == 0) ? v.en : 1'b0;
      fun3   = v.f3;
      addr   = v.a;
      wdata  = v.wd;
      bus.rdata = v.rd_in;
      bus.ack   = bus.req && (req_cnt == v.ack_at);
      @(negedge clk);
      stall_cnt += int'(stall);
      mis_cnt   += int'(misalign);
      fault_cnt += int'(fault);
      if (bus.req) begin
        check({tag, " bus"}, {27'd0, bus.we, bus.addr, bus.wdata, bus.wstrb},
              {27'd0, v.e_we, v.e_addr, v.e_wdata, v.e_wstrb});
        req_cnt++;
      end
      @(posedge clk); #1;
    end
    bus.ack = 1'b0;
    check({tag, " stall_cycles"}, 96'(stall_cnt), 96'(v.e_stall));
    check({tag, " req_cycles"},   96'(req_cnt),   96'(v.e_reqs));
    check({tag, " misalign"},     96'(mis_cnt),   96'(v.e_mis));
    check({tag, " fault"},        96'(fault_cnt), 96'(v.e_fault));
    check({tag, " rdata"},        96'(rdata),     96'(v.e_rdata));
  endtask

  vec_t vecs[11];
  vec_t v_lbu, v_tmo;

  initial begin
    rst = 1'b1; load = 1'b0; store = 1'b0; mem_en = 1'b0; fun3 = 3'd0;
    addr = '0; wdata = '0; bus.ack = 1'b0; bus.rdata = '0;

    //             ld st en f3      addr          wdata         bus_rdata     ack  stl req mis flt we  e_addr        e_wdata       strb     e_rdata
    vecs[0]  = mk(1, 0, 1, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2,  4,  3,  0,  0,  0, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF_FF80);
    vecs[1]  = mk(0, 1, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,       0,  2,  1,  0,  0,  1, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_FF80);
    vecs[2]  = mk(1, 0, 1, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0,  0,  0,  1,  0,  0, 32'h0,         32'h0,        4'b0000, 32'hFFFF_FF80);
    vecs[3]  = mk(1, 0, 1, 3'b101, 32'h0000_3002, 32'h0,        32'h5A5A_F00D, 1,  3,  2,  0,  0,  0, 32'h0000_3000, 32'h0,        4'b0000, 32'h0000_5A5A);
    vecs[4]  = mk(1, 0, 1, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0,  0,  0,  0,  1,  0, 32'h0,         32'h0,        4'b0000, 32'h0000_5A5A);
    vecs[5]  = mk(1, 1, 1, 3'b000, 32'h0000_4000, 32'h0,        32'h0,        0,  0,  0,  0,  1,  0, 32'h0,         32'h0,        4'b0000, 32'h0000_5A5A);
    vecs[6]  = mk(0, 1, 1, 3'b000, 32'h0000_5001, 32'h1234_5677, 32'h0,       0,  2,  1,  0,  0,  1, 32'h0000_5000, 32'h7777_7777, 4'b0010, 32'h0000_5A5A);
    vecs[7]  = mk(1, 0, 1, 3'b001, 32'h0000_6002, 32'h0,        32'h8001_0000, 0,  2,  1,  0,  0,  0, 32'h0000_6000, 32'h0,        4'b0000, 32'hFFFF_8001);
    vecs[8]  = mk(0, 1, 1, 3'b001, 32'h0000_7001, 32'h0000_1111, 32'h0,       0,  0,  0,  1,  0,  0, 32'h0,         32'h0,        4'b0000, 32'hFFFF_8001);
    vecs[9]  = mk(1, 0, 1, 3'b001, 32'h0000_6000, 32'h0,        32'h1234_7FFE, 0,  2,  1,  0,  0,  0, 32'h0000_6000, 32'h0,        4'b0000, 32'h0000_7FFE);
    vecs[10] = mk(1, 0, 0, 3'b000, 32'h0000_8000, 32'h0,        32'h0,        0,  0,  0,  0,  0,  0, 32'h0,         32'h0,        4'b0000, 32'h0000_7FFE);
    v_lbu    = mk(1, 0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0000_00F0, 0,  2,  1,  0,  0,  0, 32'h0,         32'h0,        4'b0000, 32'h0000_00F0);
    v_tmo    = mk(0, 1, 1, 3'b010, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0,      99,  5,  4,  0,  1,  1, 32'h0000_9000, 32'hDEAD_BEEF, 4'b1111, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst stall",    96'(stall), 96'(0));
    check("rst bus_req",  96'(bus.req), 96'(0));
    check("rst pulses",   96'({misalign, fault, bus.we}), 96'(0));
    check("rst bus_regs", {28'd0, bus.addr, bus.wdata, bus.wstrb}, 96'(0));
    check("rst rdata",    96'(rdata), 96'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset asserted mid-REQ abandons the access immediately.
    load = 1'b1; mem_en = 1'b1; fun3 = 3'b000; addr = 32'h0000_0100; bus.ack = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    check("pre_rst bus_req", 96'(bus.req), 96'(1));
    check("pre_rst stall",   96'(stall),   96'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst bus_req", 96'(bus.req), 96'(0));
    check("async_rst stall",   96'(stall),   96'(0));
    check("async_rst rdata",   96'(rdata),   96'(0));
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst idle", 96'({bus.req, stall}), 96'(0));
    run_vec("lbu_after_rst", v_lbu);

    // Timeout, then an ack arriving after the access is ignored.
    run_vec("timeout", v_tmo);
    bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ack bus_req", 96'({bus.req, stall}), 96'(0));
    @(posedge clk); #1;
    bus.ack = 1'b0;
    @(negedge clk);
    check("late_ack rdata", 96'(rdata), 96'(0));
    check("late_ack quiet", 96'({bus.req, stall, fault, misalign}), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
